// File: rtl/imem_loader_if.sv
// imem_loader_if: groups the loader's session control, byte-stream handshake
// and instruction-memory write bus so they travel as one port.
//
// Byte handshake: a byte transfers on every rising edge where byte_valid_i
// and byte_ready_o are both 1. The source holds byte_data_i stable while
// byte_valid_i is high and may drop byte_valid_i for any number of cycles.
// byte_ready_o does not depend on byte_valid_i.
//
// Signal names keep the loader's point of view (_i into the loader, _o out).
interface imem_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              load_start_i;
  logic [ADDR_W-1:0] word_count_i;
  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_ready_o;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_wdata_o;
  logic              core_rst_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  // The loader itself.
  modport slave (
    input  load_start_i, word_count_i, byte_valid_i, byte_data_i,
    output byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o,
           core_rst_o, busy_o, done_o, err_o
  );

  // Whatever drives a session (host, boot ROM, testbench).
  modport master (
    output load_start_i, word_count_i, byte_valid_i, byte_data_i,
    input  byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o,
           core_rst_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream, packs it little-endian into 32-bit
// instruction words and writes them to consecutive instruction-memory
// addresses starting at 0, holding the core in reset while loading.
// Optional trailing XOR checksum byte is compiled in when the macro
// IMEM_LOADER_CHECKSUM_EN is defined; otherwise err_o is tied to 0.
// dbg_state_o exposes the FSM state: 0 IDLE, 1 RECV, 2 WRITE, 3 CHK, 4 DONE.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  imem_loader_if.slave bus,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHK   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  // One bit wider than the address so a full 2^ADDR_W session is countable.
  logic [ADDR_W:0]   r_written;
  logic [ADDR_W:0]   r_target;
  logic [1:0]        r_byte_idx;
  logic [31:0]       r_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
  logic              r_err;
`endif

  logic              w_ready;
  logic              w_accept;
  logic [ADDR_W:0]   w_written_inc;
  logic              w_more;
  logic [ADDR_W:0]   w_target_load;

  assign w_ready       = (r_state == S_RECV) || (r_state == S_CHK);
  assign w_accept      = bus.byte_valid_i && w_ready;
  assign w_written_inc = r_written + CNT_ONE;
  assign w_more        = (w_written_inc < r_target);
  // A requested count of 0 means a full memory image.
  assign w_target_load = (bus.word_count_i == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                                  : {1'b0, bus.word_count_i};

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.load_start_i) w_next = S_RECV;
      S_RECV:  if (w_accept && (r_byte_idx == 2'd3)) w_next = S_WRITE;
      S_WRITE: begin
        if (w_more) w_next = S_RECV;
        else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_next = S_CHK;
`else
          w_next = S_DONE;
`endif
        end
      end
      S_CHK:   if (w_accept) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: counters, word assembly and checksum.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr     <= '0;
      r_written  <= '0;
      r_target   <= '0;
      r_byte_idx <= '0;
      r_wdata    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum     <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.load_start_i) begin
            r_addr     <= '0;
            r_written  <= '0;
            r_target   <= w_target_load;
            r_byte_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= '0;
            r_err      <= 1'b0;
`endif
          end
        end
        S_RECV: begin
          if (w_accept) begin
            r_wdata[{r_byte_idx, 3'b000} +: 8] <= bus.byte_data_i;
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ bus.byte_data_i;
`endif
          end
        end
        S_WRITE: begin
          r_addr    <= r_addr + ADDR_ONE;
          r_written <= w_written_inc;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_accept) r_err <= (bus.byte_data_i != r_csum);
        end
`endif
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; the write strobe is also masked by reset so
  // a reset landing on a WRITE cycle never commits the word.
  always_comb begin
    bus.byte_ready_o = w_ready;
    bus.imem_we_o    = (r_state == S_WRITE) && !rst_i;
    bus.imem_addr_o  = r_addr;
    bus.imem_wdata_o = r_wdata;
    bus.core_rst_o   = (r_state == S_RECV) || (r_state == S_WRITE) || (r_state == S_CHK);
    bus.busy_o       = (r_state == S_RECV) || (r_state == S_WRITE) || (r_state == S_CHK);
    bus.done_o       = (r_state == S_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    bus.err_o        = r_err;
`else
    bus.err_o        = 1'b0;
`endif
    dbg_state_o      = r_state;
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed sessions against imem_loader. The bench model
// turns each session's byte list into the expected (address, word) writes
// and checks every memory write as it happens.
module tb_imem_loader;
  localparam int ADDR_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  int wr_cnt    = 0;
  int done_cnt  = 0;
  logic [39:0] exp_q[$];          // {addr, word}
  logic [7:0]  tx[0:1023];        // bytes of the current session
  logic [31:0] mem[0:255];        // image as written by the DUT

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [7:0] xor_of(input int n);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < n; i++) x ^= tx[i];
    return x;
  endfunction

  // Compare process: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.imem_we_o) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {24'd0, bus.imem_addr_o}, {24'd0, e[39:32]});
        check("wr_data", bus.imem_wdata_o, e[31:0]);
      end
      check("core_rst_during_write", {31'd0, bus.core_rst_o}, 32'd1);
      mem[bus.imem_addr_o] = bus.imem_wdata_o;
    end
    if (bus.done_o) begin
      done_cnt++;
      check("busy_at_done", {31'd0, bus.busy_o}, 32'd0);
      check("core_rst_at_done", {31'd0, bus.core_rst_o}, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((bus.busy_o || bus.done_o) && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic start(input logic [7:0] cnt);
    wait_idle();
    bus.load_start_i = 1'b1;
    bus.word_count_i = cnt;
    @(posedge clk); #1;
    bus.load_start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    @(negedge clk);
    while (!bus.byte_ready_o && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) begin
      check("byte_accept_timeout", 32'd0, 32'd1);
      bus.byte_valid_i = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},    {31'd0, bus.byte_ready_o}, 32'd0);
    check({tag, "_we"},       {31'd0, bus.imem_we_o},    32'd0);
    check({tag, "_addr"},     {24'd0, bus.imem_addr_o},  32'd0);
    check({tag, "_wdata"},    bus.imem_wdata_o,          32'd0);
    check({tag, "_core_rst"}, {31'd0, bus.core_rst_o},   32'd0);
    check({tag, "_busy"},     {31'd0, bus.busy_o},       32'd0);
    check({tag, "_done"},     {31'd0, bus.done_o},       32'd0);
    check({tag, "_err"},      {31'd0, bus.err_o},        32'd0);
  endtask

  // One full session over tx[0:nbytes-1]; chk is the trailing checksum byte.
  task automatic run_session(input logic [7:0] cnt, input int nbytes, input bit gap,
                             input bit poke, input logic [7:0] chk);
    int wr0, d0, n, nw;
    logic exp_err;
    nw = nbytes / 4;
    for (int w = 0; w < nw; w++) begin
      logic [7:0] a;
      a = w[7:0];
      exp_q.push_back({a, tx[4*w+3], tx[4*w+2], tx[4*w+1], tx[4*w]});
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_err = (chk != xor_of(nbytes));
`else
    exp_err = 1'b0;
`endif
    wr0 = wr_cnt;
    d0  = done_cnt;
    start(cnt);
    check("core_rst_after_start", {31'd0, bus.core_rst_o}, 32'd1);
    check("busy_after_start",     {31'd0, bus.busy_o},     32'd1);
    check("err_after_start",      {31'd0, bus.err_o},      32'd0);
    for (int i = 0; i < nbytes; i++) begin
      send_byte(tx[i]);
      if (poke && i == 0) begin
        bus.load_start_i = 1'b1;
        bus.word_count_i = 8'd7;
        @(posedge clk); #1;
        bus.load_start_i = 1'b0;
      end
      if (gap) begin @(posedge clk); #1; end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(chk);
`endif
    n = 0;
    @(negedge clk);
    while (!bus.done_o && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("done_one_cycle", {31'd0, bus.done_o}, 32'd0);
    check("busy_after_done", {31'd0, bus.busy_o}, 32'd0);
    check("write_count", wr_cnt - wr0, nw);
    check("done_count", done_cnt - d0, 32'd1);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("err_flag", {31'd0, bus.err_o}, {31'd0, exp_err});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.load_start_i = 1'b0;
    bus.word_count_i = '0;
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset_state", {29'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Two-word program from the spec example.
    tx[0] = 8'h13; tx[1] = 8'h00; tx[2] = 8'h00; tx[3] = 8'h00;
    tx[4] = 8'h93; tx[5] = 8'h00; tx[6] = 8'h10; tx[7] = 8'h00;
    run_session(8'd2, 8, 1'b0, 1'b0, xor_of(8));
    check("pin_mem0", mem[0], 32'h0000_0013);
    check("pin_mem1", mem[1], 32'h0010_0093);

    // Same single word without and with valid gaps.
    tx[0] = 8'hEF; tx[1] = 8'hBE; tx[2] = 8'hAD; tx[3] = 8'hDE;
    run_session(8'd1, 4, 1'b0, 1'b0, xor_of(4));
    check("pin_nogap", mem[0], 32'hDEAD_BEEF);
    mem[0] = 32'h0;
    run_session(8'd1, 4, 1'b1, 1'b0, xor_of(4));
    check("pin_gap", mem[0], 32'hDEAD_BEEF);

    // load_start pulsed mid-RECV must be ignored.
    for (int i = 0; i < 8; i++) tx[i] = 8'(8'hA0 + i);
    run_session(8'd2, 8, 1'b0, 1'b1, xor_of(8));
    check("pin_poke_mem1", mem[1], 32'hA7A6_A5A4);

    // word_count 0: full 256-word image.
    for (int j = 0; j < 1024; j++) tx[j] = j[7:0];
    run_session(8'd0, 1024, 1'b0, 1'b0, xor_of(1024));
    check("pin_full_mem0",   mem[0],   32'h0302_0100);
    check("pin_full_mem255", mem[255], 32'hFFFE_FDFC);

    // Reset after two bytes of the first word: nothing written.
    begin
      int wr0;
      wr0 = wr_cnt;
      start(8'd2);
      send_byte(8'h11);
      send_byte(8'h22);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check_all_zero("midreset");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("midreset_no_write", wr_cnt - wr0, 32'd0);
    end
    tx[0] = 8'hAA; tx[1] = 8'hBB; tx[2] = 8'hCC; tx[3] = 8'hDD;
    run_session(8'd1, 4, 1'b0, 1'b0, xor_of(4));
    check("pin_after_reset", mem[0], 32'hDDCC_BBAA);

`ifdef IMEM_LOADER_CHECKSUM_EN
    tx[0] = 8'h01; tx[1] = 8'h02; tx[2] = 8'h04; tx[3] = 8'h08;
    run_session(8'd1, 4, 1'b0, 1'b0, 8'h0F);
    check("pin_chk_good", {31'd0, bus.err_o}, 32'd0);
    run_session(8'd1, 4, 1'b0, 1'b0, 8'h0E);
    check("pin_chk_bad", {31'd0, bus.err_o}, 32'd1);
    repeat (3) @(negedge clk);
    check("err_held", {31'd0, bus.err_o}, 32'd1);
    run_session(8'd1, 4, 1'b0, 1'b0, 8'h0F);
`else
    repeat (3) @(negedge clk);
    check("err_tied_low", {31'd0, bus.err_o}, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction memory word-address width.
REQ-002 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-003 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-004 SHALL have port load_start_i  input  1  begins a load session; sampled only in IDLE.
REQ-005 SHALL have port word_count_i  input  ADDR_W  words to load; sampled with load_start_i; 0 means 2^ADDR_W.
REQ-006 SHALL have port byte_valid_i  input  1  source byte valid.
REQ-007 SHALL have port byte_data_i  input  8  source byte.
REQ-008 SHALL have port byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port imem_we_o  output  1  instruction memory write strobe.
REQ-010 SHALL have port imem_addr_o  output  ADDR_W  instruction memory write address.
REQ-011 SHALL have port imem_wdata_o  output  32  instruction word to write.
REQ-012 SHALL have port core_rst_o  output  1  holds the pipeline data path in reset during a load.
REQ-013 SHALL have port busy_o  output  1  session in progress.
REQ-014 SHALL have port done_o  output  1  one-cycle pulse at session end.
REQ-015 SHALL have port err_o  output  1  checksum mismatch flag.

Function
REQ-016 SHALL implement states IDLE, RECV, WRITE, CHK, DONE.
REQ-017 SHALL move IDLE->RECV on load_start_i=1, clear address counter, word counter, byte index and running checksum.
REQ-018 SHALL ignore load_start_i outside IDLE.
REQ-019 SHALL accept a byte only when byte_valid_i and byte_ready_o are both 1; byte_ready_o=1 only in RECV and CHK.
REQ-020 SHALL assemble bytes little-endian: byte 0 -> wdata[7:0], byte 3 -> wdata[31:24].
REQ-021 SHALL move RECV->WRITE on the cycle the 4th byte is accepted.
REQ-022 SHALL in WRITE assert imem_we_o for exactly one cycle with imem_addr_o = current address and imem_wdata_o = assembled word.
REQ-023 SHALL increment the address modulo 2^ADDR_W after each write; the write at address 2^ADDR_W-1 wraps to 0.
REQ-024 SHALL move WRITE->RECV if words written < word count, else to CHK (macro defined) or DONE (macro undefined).
REQ-025 SHALL hold imem_we_o=0 in every state other than WRITE.
REQ-026 SHALL assert core_rst_o and busy_o in RECV, WRITE and CHK; deassert in IDLE and DONE.
REQ-027 SHALL in DONE pulse done_o for one cycle, then return to IDLE.
REQ-028 SHALL tolerate byte_valid_i gaps of any length without state change.
REQ-029 SHALL write no word with fewer than 4 accepted bytes.

Reset
REQ-030 SHALL on rst_i=1 enter IDLE at the next rising edge regardless of state.
REQ-031 SHALL set byte_ready_o=0, imem_we_o=0, imem_addr_o=0, imem_wdata_o=0, core_rst_o=0, busy_o=0, done_o=0 and err_o=0 on reset.
REQ-032 SHALL discard any partial word on reset mid-session, with no memory write in the reset cycle.

Configuration
REQ-033 SHALL compile the checksum stage only when macro IMEM_LOADER_CHECKSUM_EN is defined.
REQ-034 SHALL with the macro keep a running XOR of all accepted data bytes; in CHK accept one byte and set err_o=1 if it differs from the running XOR, else set err_o=0, then go to DONE.
REQ-035 SHALL with the macro hold err_o until the next load_start_i acceptance or reset.
REQ-036 SHALL without the macro never enter CHK and tie err_o to 0.

Verification
REQ-037 SHALL cover: word_count=2, bytes 13,00,00,00,93,00,10,00 -> writes addr0=0x00000013, addr1=0x00100093, done_o one pulse, core_rst_o high from start to DONE.
REQ-038 SHALL cover: byte_valid_i toggled 1/0 each cycle, word_count=1 -> single write identical to gap-free case, imem_we_o high exactly one cycle.
REQ-039 SHALL cover: word_count=0, ADDR_W=8 -> 256 writes at addresses 0..255, then done_o.
REQ-040 SHALL cover: rst_i after 2 bytes of word 1 -> no write, all outputs 0, next session starts at address 0.
REQ-041 SHALL cover (macro defined): word_count=1, bytes 01,02,04,08 then check byte 0x0F -> err_o=0; check byte 0x0E -> err_o=1.
REQ-042 SHALL cover: load_start_i pulsed during RECV -> ignored, counters unchanged.
